inv_subbytes_stage: RTL

Flow-controlled 128-bit InvShiftRows + InvSubBytes stage of the AES-128 decryptor datapath. Accepts a round state from the round controller, optionally applies InvShiftRows, and runs all 16 bytes through free-running 3-register inverse S-box lanes. Results are buffered in an output FIFO so downstream backpressure (AddRoundKey/InvMixColumns) never corrupts the non-stallable lanes. A 4-bit tag travels alongside each state.

---
 rtl/inv_subbytes_stage.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/inv_subbytes_stage.sv
// -----------------------------------------------------------------------------
// inv_subbytes_stage
//
// AES-128 decryptor datapath stage: optional InvShiftRows followed by
// InvSubBytes on a 128-bit state. The 16 byte lanes are free-running
// 3-register pipelines with no enable. An output FIFO absorbs downstream
// backpressure. Credit-based admission keeps the FIFO from overflowing.
//
// Build option:
//   INV_SUBBYTES_SHIFTROWS_EN  defined     -> InvShiftRows applied before the lanes
//                              not defined -> pure InvSubBytes (byte i -> lane i)
//
// Ports:
//   clk, rst           single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready depends on registers and rst only)
//   in_state[127:0]    byte i = in_state[127-8i -: 8], FIPS-197 column-major
//   in_tag[3:0]        opaque tag carried with the state
//   out_valid/out_ready downstream handshake (FIFO head)
//   out_state[127:0]   processed state, forced to 0 when the FIFO is empty
//   out_tag[3:0]       tag of the head entry, forced to 0 when the FIFO is empty
//   fifo_level         FIFO occupancy
// -----------------------------------------------------------------------------
module inv_subbytes_stage #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [127:0]                  in_state,
    input  logic [3:0]                    in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [127:0]                  out_state,
    output logic [3:0]                    out_tag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int USE_W = LVL_W + 1;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        return gf_mul(a, a);
    endfunction

    // Inverse of the S-box affine transform; the multiplicative inverse
    // that follows completes the inverse S-box.
    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    // ------------------------------------------------------------------
    // Handshake bookkeeping
    // ------------------------------------------------------------------
    logic [2:0]       valid_sr_reg;
    logic [2:0][3:0]  tag_sr_reg;
    logic [LVL_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [USE_W-1:0] used;
    logic             in_xfer;
    logic             fifo_wr;
    logic             fifo_rd;

    // Credits count both in-flight lane contents and buffered entries, so
    // everything admitted is guaranteed a FIFO slot when it leaves the lanes.
    assign used = USE_W'(count_reg)
                + USE_W'(valid_sr_reg[0])
                + USE_W'(valid_sr_reg[1])
                + USE_W'(valid_sr_reg[2]);
    assign in_ready = !rst && (used < USE_W'(FIFO_DEPTH));
    assign in_xfer  = in_valid && in_ready;
    assign fifo_wr  = valid_sr_reg[2];
    assign fifo_rd  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_sr_reg <= 3'b000;
            tag_sr_reg   <= '0;
        end else begin
            valid_sr_reg <= {valid_sr_reg[1:0], in_xfer};
            tag_sr_reg   <= {tag_sr_reg[1:0], in_tag};
        end
    end

    // ------------------------------------------------------------------
    // Byte lanes: inverse affine -> partial powers -> x^254 (= x^-1)
    // ------------------------------------------------------------------
    logic [7:0] lane_out [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
`ifdef INV_SUBBYTES_SHIFTROWS_EN
            // out(r,c) = in(r,(c-r) mod 4), with byte index r + 4c
            localparam int SRC = (gi % 4) + 4 * (((gi / 4) - (gi % 4) + 4) % 4);
`else
            localparam int SRC = gi;
`endif
            logic [7:0] lane_in;
            logic [7:0] s1_reg;
            logic [7:0] s2a_reg;
            logic [7:0] s2b_reg;
            logic [7:0] s3_reg;
            logic [7:0] b2;
            logic [7:0] b3;
            logic [7:0] b12;
            logic [7:0] b14;
            logic [7:0] b15;
            logic [7:0] b240;

            assign lane_in = in_state[127-8*SRC -: 8];

            // 254 = 14 + 240; 240 = 15 * 16 so b^240 is b^15 squared four times.
            assign b2   = gf_sq(s1_reg);
            assign b3   = gf_mul(b2, s1_reg);
            assign b12  = gf_sq(gf_sq(b3));
            assign b14  = gf_mul(b12, b2);
            assign b15  = gf_mul(b12, b3);
            assign b240 = gf_sq(gf_sq(gf_sq(gf_sq(b15))));

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_reg  <= 8'h00;
                    s2a_reg <= 8'h00;
                    s2b_reg <= 8'h00;
                    s3_reg  <= 8'h00;
                end else begin
                    s1_reg  <= inv_affine(lane_in);
                    s2a_reg <= b14;
                    s2b_reg <= b240;
                    s3_reg  <= gf_mul(s2a_reg, s2b_reg);
                end
            end

            assign lane_out[gi] = s3_reg;
        end
    endgenerate

    logic [127:0] lane_state;

    always_comb begin
        lane_state = '0;
        for (int i = 0; i < 16; i++) begin
            lane_state[127-8*i -: 8] = lane_out[i];
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [131:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_reg] <= {tag_sr_reg[2], lane_state};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            assert (!(fifo_wr && !fifo_rd && count_reg == LVL_W'(FIFO_DEPTH)));
            if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   count_reg <= count_reg + LVL_W'(1);
                2'b01:   count_reg <= count_reg - LVL_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    logic [131:0] head;

    assign head       = mem[rd_ptr_reg];
    assign out_valid  = (count_reg != '0);
    assign out_state  = out_valid ? head[127:0]   : 128'h0;
    assign out_tag    = out_valid ? head[131:128] : 4'h0;
    assign fifo_level = count_reg;

endmodule
